// File: rtl/mix_columns_seq.sv
`timescale 1ns/1ps
// AES MixColumns round stage: COLS_PER_CYCLE columns mixed per clock, in place, in a working register.
// One state in flight; input accepted only in IDLE, output held in DONE until out_ready.
module mix_columns_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         last_round,
   input  logic [127:0] mixcol_i,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] mixcol_o,
   output logic         busy
);

   generate
      if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cpc
         $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

   state_t       state, state_nxt;
   logic [1:0]   col_cnt;
   logic [127:0] work_reg, work_mixed;

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // Only the columns of the current group are replaced; the rest pass through.
   always_comb begin : p_mix
      logic [1:0] off;
      logic [7:0] a0, a1, a2, a3;
      work_mixed = work_reg;
      for (int c = 0; c < 4; c++) begin
         off = 2'(c) - col_cnt;
         a0  = work_reg[8*c      +: 8];
         a1  = work_reg[8*(4+c)  +: 8];
         a2  = work_reg[8*(8+c)  +: 8];
         a3  = work_reg[8*(12+c) +: 8];
         if ({1'b0, off} < 3'(COLS_PER_CYCLE)) begin
            work_mixed[8*c      +: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
            work_mixed[8*(4+c)  +: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
            work_mixed[8*(8+c)  +: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
            work_mixed[8*(12+c) +: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid) state_nxt = last_round ? DONE : BUSY;
         BUSY:    if (col_cnt == CNT_LAST) state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         col_cnt  <= 2'd0;
         work_reg <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (in_valid) begin
               work_reg <= mixcol_i;
               col_cnt  <= 2'd0;
            end
            BUSY: begin
               work_reg <= work_mixed;
               col_cnt  <= col_cnt + CNT_STEP;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign busy      = (state == BUSY);
   assign out_valid = (state == DONE);
   assign mixcol_o  = work_reg;

endmodule

// File: tb/tb_mix_columns_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for mix_columns_seq: three instances (1, 2, 4 columns per cycle) driven in turn,
// expected states queued at acceptance and compared when the stage hands the result downstream.
module tb_mix_columns_seq;

   localparam int NI = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid   [NI];
   logic         in_ready   [NI];
   logic         last_round [NI];
   logic [127:0] mixcol_i   [NI];
   logic         out_valid  [NI];
   logic         out_ready  [NI];
   logic [127:0] mixcol_o   [NI];
   logic         busy       [NI];

   int n_cmp = 0;
   int n_bad = 0;
   logic [127:0] exp_q[$];

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .in_valid   (in_valid[g]),
         .in_ready   (in_ready[g]),
         .last_round (last_round[g]),
         .mixcol_i   (mixcol_i[g]),
         .out_valid  (out_valid[g]),
         .out_ready  (out_ready[g]),
         .mixcol_o   (mixcol_o[g]),
         .busy       (busy[g])
      );
   end

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Independent reference: generic GF(2^8) multiply, circulant matrix (2 3 1 1).
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [127:0] mix_ref(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   a [4];
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 4; k++) a[k] = s[8*(4*k+c) +: 8];
         for (int k = 0; k < 4; k++)
            r[8*(4*k+c) +: 8] = gmul(a[k], 8'd2) ^ gmul(a[(k+1)%4], 8'd3) ^ a[(k+2)%4] ^ a[(k+3)%4];
      end
      return r;
   endfunction

   function automatic logic [127:0] model(input logic [127:0] s, input logic lr);
      return lr ? s : mix_ref(s);
   endfunction

   // Columns written as a0a1a2a3 (row 0 in the most significant byte).
   function automatic logic [127:0] pack_cols(input logic [31:0] c0, input logic [31:0] c1,
                                              input logic [31:0] c2, input logic [31:0] c3);
      logic [127:0] s;
      logic [31:0]  col [4];
      col[0] = c0; col[1] = c1; col[2] = c2; col[3] = c3;
      s = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) s[8*(4*r+c) +: 8] = col[c][31-8*r -: 8];
      return s;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One state through the stage; in_valid stays high with junk data until release to prove it is ignored.
   task automatic run_state(input int d, input logic [127:0] data, input logic lr, input int hold,
                            input logic [127:0] exp);
      int n;
      bit seen_busy;
      logic [127:0] held;
      in_valid[d]   = 1'b1;
      mixcol_i[d]   = data;
      last_round[d] = lr;
      out_ready[d]  = 1'b0;
      n = 0;
      while (!in_ready[d] && n < 20) begin tick(); n++; end
      check("in_ready_idle", 128'(in_ready[d]), 128'd1);
      exp_q.push_back(exp);
      tick();
      mixcol_i[d]   = ~data;
      last_round[d] = ~lr;
      check("in_ready_after_acc", 128'(in_ready[d]), 128'd0);
      n = 0;
      seen_busy = 1'b0;
      while (!out_valid[d] && n < 20) begin
         seen_busy |= busy[d];
         tick();
         n++;
      end
      check("latency", 128'(n), lr ? 128'd0 : 128'(4 >> d));
      check("busy_seen", 128'(seen_busy), 128'(!lr));
      held = mixcol_o[d];
      repeat (hold) begin
         tick();
         check("hold_vld", 128'(out_valid[d]), 128'd1);
         check("hold_dat", mixcol_o[d], held);
         check("hold_rdy", 128'(in_ready[d]), 128'd0);
      end
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b1;
      check("result", mixcol_o[d], exp_q.pop_front());
      tick();
      out_ready[d] = 1'b0;
      check("idle_rdy", 128'(in_ready[d]), 128'd1);
      check("idle_vld", 128'(out_valid[d]), 128'd0);
   endtask

   task automatic reset_mid(input int d, input logic [127:0] data);
      in_valid[d]   = 1'b1;
      mixcol_i[d]   = data;
      last_round[d] = 1'b0;
      tick();
      in_valid[d] = 1'b0;
      repeat ((d == 0) ? 2 : 1) tick();
      rst_n = 1'b0;
      #1;
      check("rst_vld", 128'(out_valid[d]), 128'd0);
      check("rst_dat", mixcol_o[d], 128'd0);
      check("rst_busy", 128'(busy[d]), 128'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("rst_rdy", 128'(in_ready[d]), 128'd1);
   endtask

   task automatic rand_run(input int d, input int num);
      int acc, got, cyc;
      bit pend, prev_hold;
      logic [127:0] cur, prev_dat;
      logic cur_lr;
      acc = 0; got = 0; cyc = 0;
      pend = 1'b0; prev_hold = 1'b0;
      cur = '0; cur_lr = 1'b0; prev_dat = '0;
      while (got < num && cyc < 12 * num) begin
         if (prev_hold) begin
            check("rnd_hold_vld", 128'(out_valid[d]), 128'd1);
            check("rnd_hold_dat", mixcol_o[d], prev_dat);
         end
         if (!pend && acc < num && $urandom_range(0, 3) != 0) begin
            cur    = rand128();
            cur_lr = ($urandom_range(0, 7) == 0);
            pend   = 1'b1;
         end
         in_valid[d]   = pend;
         mixcol_i[d]   = cur;
         last_round[d] = cur_lr;
         out_ready[d]  = ($urandom_range(0, 2) != 0);
         if (out_valid[d] && out_ready[d]) begin
            if (exp_q.size() == 0) check("rnd_spurious_vld", 128'(out_valid[d]), 128'd0);
            else check("rnd_dat", mixcol_o[d], exp_q.pop_front());
            got++;
         end
         if (in_valid[d] && in_ready[d]) begin
            exp_q.push_back(model(cur, cur_lr));
            pend = 1'b0;
            acc++;
         end
         prev_hold = out_valid[d] && !out_ready[d];
         prev_dat  = mixcol_o[d];
         tick();
         cyc++;
      end
      in_valid[d]  = 1'b0;
      out_ready[d] = 1'b0;
      check("rnd_count", 128'(got), 128'(num));
      check("rnd_drain", 128'(exp_q.size()), 128'd0);
      exp_q.delete();
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] fips_in, fips_out, mix_in, mix_out, lr_val;
      fips_in  = 128'h30303030_5d5d5d5d_bfbfbfbf_d4d4d4d4;
      fips_out = 128'he5e5e5e5_81818181_66666666_04040404;
      mix_in   = pack_cols(32'hdb135345, 32'hf20a225c, 32'h01010101, 32'h2d26314c);
      mix_out  = pack_cols(32'h8e4da1bc, 32'h9fdc589d, 32'h01010101, 32'h4d7ebdf8);
      lr_val   = 128'h0123456789abcdef0123456789abcdef;

      rst_n = 1'b0;
      for (int d = 0; d < NI; d++) begin
         in_valid[d] = 1'b0; last_round[d] = 1'b0; mixcol_i[d] = '0; out_ready[d] = 1'b0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < NI; d++) begin
         check("reset_vld", 128'(out_valid[d]), 128'd0);
         check("reset_busy", 128'(busy[d]), 128'd0);
         check("reset_dat", mixcol_o[d], 128'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      for (int d = 0; d < NI; d++) check("reset_rdy", 128'(in_ready[d]), 128'd1);

      for (int d = 0; d < NI; d++) begin
         logic [127:0] fresh;
         run_state(d, fips_in, 1'b0, 0, fips_out);
         run_state(d, mix_in, 1'b0, 0, mix_out);
         run_state(d, lr_val, 1'b1, 0, lr_val);
         run_state(d, mix_in, 1'b0, 10, mix_out);
         run_state(d, lr_val, 1'b1, 3, lr_val);
         reset_mid(d, mix_in);
         fresh = rand128();
         run_state(d, fresh, 1'b0, 0, mix_ref(fresh));
         rand_run(d, (d == 0) ? 1000 : 300);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
